// File: rtl/spi_adc_model.sv
// SPI slave model of a multi-channel ADC (ADC128S-style): pipelined channel select,
// error pulses and a frame counter. Define ADC_NOISE_EN to add +/-1 LSB LFSR noise.
module spi_adc_model #(
    parameter int NUM_CH      = 8,
    parameter int DATA_W      = 12,
    parameter int FRAME_W     = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic                     SS_n,
    input  logic                     SCLK,
    input  logic                     MOSI,
    output logic                     MISO,
    output logic                     frame_done,
    output logic                     frame_err,
    output logic [2:0]               cur_ch,
    output logic [15:0]              frame_cnt
);

    localparam int                CNT_W    = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FRAME_W);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    logic [SYNC_STAGES-1:0] r_ss_sync, r_sclk_sync, r_mosi_sync;
    logic                   r_ss_prev, r_sclk_prev;
    state_t                 r_state;
    logic [FRAME_W-1:0]     r_tx_sr;
    logic [FRAME_W-3:0]     r_rx_sr;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic                   r_frame_done, r_frame_err;
    logic [2:0]             r_cur_ch;
    logic [15:0]            r_frame_cnt;

    logic                   w_ss, w_ss_fall, w_ss_rise, w_sclk_rise, w_sclk_fall, w_mosi;
    logic [DATA_W-1:0]      w_sample, w_snap;
    logic [2:0]             w_addr;

    // Synchronisers reset to 0 so SS_n must be seen high before a fall can start a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ss_sync   <= '0;
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_ss_prev   <= 1'b0;
            r_sclk_prev <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every stage take the previous stage's old value.
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], SS_n};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
            r_ss_prev   <= r_ss_sync[SYNC_STAGES-1];
            r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
        end
    end

    assign w_ss        = r_ss_sync[SYNC_STAGES-1];
    assign w_ss_fall   = r_ss_prev & ~w_ss;
    assign w_ss_rise   = ~r_ss_prev & w_ss;
    assign w_sclk_rise = ~r_sclk_prev & r_sclk_sync[SYNC_STAGES-1];
    assign w_sclk_fall = r_sclk_prev & ~r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_addr      = r_rx_sr[FRAME_W-3 -: 3];

    always_comb begin
        // NOTE: default first so no path through the loop leaves w_sample unassigned (no latch).
        w_sample = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (r_cur_ch == 3'(k)) w_sample = ch_data[k*DATA_W +: DATA_W];
        end
    end

`ifdef ADC_NOISE_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= 16'hACE1;
        end else if (r_state == IDLE && w_ss_fall) begin
            r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    // LFSR[1:0]: 00 -> -1 LSB, 11 -> +1 LSB, otherwise exact; saturating at both rails.
    always_comb begin
        w_snap = w_sample;
        case (r_lfsr[1:0])
            2'b00:   if (w_sample != '0) w_snap = w_sample - DATA_W'(1);
            2'b11:   if (w_sample != '1) w_snap = w_sample + DATA_W'(1);
            default: w_snap = w_sample;
        endcase
    end
`else
    assign w_snap = w_sample;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_tx_sr      <= '0;
            r_rx_sr      <= '0;
            r_bit_cnt    <= '0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            r_cur_ch     <= 3'd0;
            r_frame_cnt  <= 16'd0;
        end else begin
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_ss_fall) begin
                        r_tx_sr   <= FRAME_W'(w_snap);
                        r_rx_sr   <= '0;
                        r_bit_cnt <= '0;
                        r_state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    // SS_n edges take priority over any SCLK edge detected in the same cycle.
                    if (w_ss_rise) begin
                        r_tx_sr <= '0;
                        if (r_bit_cnt == FULL_CNT) begin
                            r_state <= DONE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= IDLE;
                        end
                    end else if (w_sclk_rise) begin
                        if (r_bit_cnt != FULL_CNT) begin
                            r_rx_sr   <= {r_rx_sr[FRAME_W-4:0], w_mosi};
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else if (w_sclk_fall) begin
                        r_tx_sr <= (r_bit_cnt == FULL_CNT) ? '0 : (r_tx_sr << 1);
                    end
                end
                DONE: begin
                    if (int'(w_addr) < NUM_CH) r_cur_ch <= w_addr;
                    else                       r_frame_err <= 1'b1;
                    r_frame_done <= 1'b1;
                    r_frame_cnt  <= r_frame_cnt + 16'd1;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign MISO       = r_tx_sr[FRAME_W-1];
    assign frame_done = r_frame_done;
    assign frame_err  = r_frame_err;
    assign cur_ch     = r_cur_ch;
    assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_spi_adc_model.sv
// Self-checking bench for spi_adc_model (3 channels): transaction-level model of the
// channel pipeline, error rules and frame counter; random frames plus directed cases.
module tb_spi_adc_model;
    localparam int NUM_CH = 3;
    localparam int DATA_W = 12;
    localparam int HALF   = 8;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic                     SS_n, SCLK, MOSI;
    logic                     MISO, frame_done, frame_err;
    logic [2:0]               cur_ch;
    logic [15:0]              frame_cnt;

    spi_adc_model #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .FRAME_W(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .ch_data(ch_data), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
        .MISO(MISO), .frame_done(frame_done), .frame_err(frame_err),
        .cur_ch(cur_ch), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          done_seen = 0;
    int          err_seen  = 0;
    int          ss_hi = 0;
    int          poke_bit = -1;
    int          m_ch = 0;
    logic [15:0] m_cnt = 16'd0;
    logic [15:0] got;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Pulse counting and the idle-MISO rule, every cycle.
    always @(negedge clk) begin
        if (frame_done === 1'b1) done_seen++;
        if (frame_err === 1'b1) err_seen++;
        if (SS_n) ss_hi++;
        else      ss_hi = 0;
        if (ss_hi > 6) check("idle_miso", {31'b0, MISO}, 32'd0);
    end

    // Mode-0 master: MISO is captured just before each SCLK rise.
    task automatic frame(input logic [15:0] mosi_w, input int nbits, input bit raise_ss);
        got  = 16'h0;
        SS_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (i < 16) MOSI = mosi_w[15-i];
            else        MOSI = 1'b0;
            if (i == poke_bit) ch_data = ~ch_data;
            repeat (HALF) @(negedge clk);
            if (i < 16) got = {got[14:0], MISO};
            SCLK = 1'b1;
            repeat (HALF) @(negedge clk);
            SCLK = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        if (raise_ss) begin
            SS_n = 1'b1;
            repeat (2*HALF) @(negedge clk);
        end
    endtask

    task automatic full_frame(input logic [15:0] mosi_w, input int nbits);
        logic [DATA_W-1:0] exp_v;
        int d0, e0, a;
        bit bad;
        exp_v = ch_data[m_ch*DATA_W +: DATA_W];
        d0 = done_seen;
        e0 = err_seen;
        a  = int'(mosi_w[13:11]);
        frame(mosi_w, nbits, 1'b1);
`ifdef ADC_NOISE_EN
        begin
            logic [15:0] lo, hi;
            lo = (exp_v == 12'h000) ? 16'h0 : {4'h0, exp_v - 12'd1};
            hi = (exp_v == 12'hFFF) ? 16'hFFF : {4'h0, exp_v + 12'd1};
            check("frame_data_range", {31'b0, (got >= lo) && (got <= hi)}, 32'd1);
        end
`else
        check("frame_data", {16'h0, got}, {20'h0, exp_v});
`endif
        bad = (a >= NUM_CH);
        if (!bad) m_ch = a;
        m_cnt = m_cnt + 16'd1;
        check("done_pulses", done_seen - d0, 1);
        check("err_pulses", err_seen - e0, bad ? 1 : 0);
        check("cur_ch", {29'b0, cur_ch}, m_ch);
        check("frame_cnt", {16'b0, frame_cnt}, {16'b0, m_cnt});
    endtask

    task automatic abort_frame(input logic [15:0] mosi_w, input int nbits);
        int d0, e0;
        d0 = done_seen;
        e0 = err_seen;
        frame(mosi_w, nbits, 1'b1);
        check("abort_done", done_seen - d0, 0);
        check("abort_err", err_seen - e0, 1);
        check("abort_cur_ch", {29'b0, cur_ch}, m_ch);
        check("abort_cnt", {16'b0, frame_cnt}, {16'b0, m_cnt});
    endtask

    initial begin
        int d0, e0, r;
        rst = 1'b1; SS_n = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
        ch_data = {12'h777, 12'h3C3, 12'h156};
        repeat (3) @(negedge clk);
        check("rst_miso", {31'b0, MISO}, 0);
        check("rst_done", {31'b0, frame_done}, 0);
        check("rst_err", {31'b0, frame_err}, 0);
        check("rst_cur_ch", {29'b0, cur_ch}, 0);
        check("rst_cnt", {16'b0, frame_cnt}, 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // First frame returns ch0.
        full_frame(16'h0000, 16);
`ifndef ADC_NOISE_EN
        check("t1_literal", {16'h0, got}, 32'h0156);
`endif
        check("t1_cnt_literal", {16'b0, frame_cnt}, 32'd1);

        // Address 2 takes effect one frame later.
        full_frame(16'h1000, 16);
`ifndef ADC_NOISE_EN
        check("t2a_literal", {16'h0, got}, 32'h0156);
`endif
        ch_data[2*DATA_W +: DATA_W] = 12'hA5C;
        full_frame(16'h0000, 16);
`ifndef ADC_NOISE_EN
        check("t2b_literal", {16'h0, got}, 32'h0A5C);
`endif

        // Out-of-range address keeps the current channel.
        full_frame(16'h0800, 16);
        full_frame(16'h3800, 16);
        check("t3_cur_ch_literal", {29'b0, cur_ch}, 32'd1);

        // Abort after 9 SCLKs, then the pending channel (2) is still served.
        full_frame(16'h1000, 16);
        abort_frame(16'h0800, 9);
        full_frame(16'h1000, 16);
`ifndef ADC_NOISE_EN
        check("t4_literal", {16'h0, got}, 32'h0A5C);
`endif

        // Reset mid-frame with SS_n held low.
        ch_data[2*DATA_W +: DATA_W] = 12'h7FF;
        frame(16'h0800, 5, 1'b0);
`ifndef ADC_NOISE_EN
        check("t5_pre_miso", {31'b0, MISO}, 1);
`endif
        rst = 1'b1;
        @(negedge clk);
        check("t5_miso", {31'b0, MISO}, 0);
        check("t5_cur_ch", {29'b0, cur_ch}, 0);
        check("t5_cnt", {16'b0, frame_cnt}, 0);
        m_ch = 0; m_cnt = 16'd0;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        d0 = done_seen; e0 = err_seen;
        for (int i = 0; i < 3; i++) begin
            SCLK = 1'b1; repeat (HALF) @(negedge clk);
            SCLK = 1'b0; repeat (HALF) @(negedge clk);
        end
        check("t5_held_miso", {31'b0, MISO}, 0);
        SS_n = 1'b1;
        repeat (2*HALF) @(negedge clk);
        check("t5_no_pulses", (done_seen - d0) + (err_seen - e0), 0);
        full_frame(16'h0000, 16);
`ifndef ADC_NOISE_EN
        check("t5_literal", {16'h0, got}, 32'h0156);
`endif

        // ch_data changes mid-frame do not reach the frame; extra SCLKs are harmless.
        poke_bit = 6;
        full_frame(16'h0000, 16);
        poke_bit = -1;
        full_frame(16'h0800, 18);

        for (int n = 0; n < 60; n++) begin
            ch_data = {$urandom, $urandom};
            r = int'($urandom_range(0, 9));
            if (r == 0) abort_frame(16'($urandom), int'($urandom_range(1, 15)));
            else        full_frame(16'($urandom), (r == 1) ? int'($urandom_range(17, 19)) : 16);
        end

`ifdef ADC_NOISE_EN
        // Saturation at full scale: result stays in 0xFFE..0xFFF.
        full_frame(16'h0000, 16);
        ch_data[0 +: DATA_W] = 12'hFFF;
        for (int n = 0; n < 64; n++) begin
            full_frame(16'h0000, 16);
            check("t6_range", {31'b0, (got == 16'hFFE) || (got == 16'hFFF)}, 1);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
